alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 16 +
 rtl/alu_arbiter_core.sv | 39 +++
 rtl/alu_arbiter.sv | 114 +++++++++++
 tb/tb_alu_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared opcodes and FSM state type for the two-port ALU arbiter.
// Optional flags feature is selected with ALU_ARB_FLAGS_EN.
package alu_arb_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_arbiter_core.sv
// Combinational W-bit ALU: add, sub, and, or.
// carry port exists only when ALU_ARB_FLAGS_EN is defined.
import alu_arb_pkg::*;

module alu_core #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
`ifdef ALU_ARB_FLAGS_EN
  output logic         carry,
`endif
  output logic [W-1:0] result
);

  logic [W:0] wide;

  // bit W is carry-out for add and borrow for sub
  always_comb begin
    wide = '0;
    unique case (op)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      default: wide = {1'b0, a | b};
    endcase
  end

  assign result = wide[W-1:0];

`ifdef ALU_ARB_FLAGS_EN
  assign carry = wide[W];
`else
  logic unused_carry;
  assign unused_carry = wide[W];
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter for two requesters sharing one ALU.
// Zero/carry response flags exist only when ALU_ARB_FLAGS_EN is defined.
import alu_arb_pkg::*;

module alu_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [1:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [1:0]   req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
`ifdef ALU_ARB_FLAGS_EN
  output logic         rsp_zero,
  output logic         rsp_carry,
`endif
  output logic [W-1:0] rsp_result
);

  state_t       state;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [1:0]   op_q;
  logic         id_q;
  logic         last;
  logic [W-1:0] alu_res;
  logic         idle;

  assign idle = (state == IDLE);

  // on a tie the requester not granted last wins
  assign req0_ready = idle & req0_valid & (~req1_valid | last);
  assign req1_ready = idle & req1_valid & (~req0_valid | ~last);

`ifdef ALU_ARB_FLAGS_EN
  logic alu_carry;
`endif

  alu_core #(.W(W)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
`ifdef ALU_ARB_FLAGS_EN
    .carry  (alu_carry),
`endif
    .result (alu_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      id_q       <= 1'b0;
      last       <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
`ifdef ALU_ARB_FLAGS_EN
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req0_ready) begin
            a_q   <= req0_a;
            b_q   <= req0_b;
            op_q  <= req0_op;
            id_q  <= 1'b0;
            last  <= 1'b0;
            state <= EXEC;
          end else if (req1_ready) begin
            a_q   <= req1_a;
            b_q   <= req1_b;
            op_q  <= req1_op;
            id_q  <= 1'b1;
            last  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_res;
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
`ifdef ALU_ARB_FLAGS_EN
          rsp_zero   <= (alu_res == '0);
          rsp_carry  <= (op_q == OP_ADD || op_q == OP_SUB) & alu_carry;
`endif
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (W=4).
// Flag checks are compiled in when ALU_ARB_FLAGS_EN is defined.
`timescale 1ns/1ps
import alu_arb_pkg::*;

module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0;
  logic       req0_ready;
  logic [3:0] req0_a = '0;
  logic [3:0] req0_b = '0;
  logic [1:0] req0_op = '0;
  logic       req1_valid = 1'b0;
  logic       req1_ready;
  logic [3:0] req1_a = '0;
  logic [3:0] req1_b = '0;
  logic [1:0] req1_op = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_id;
  logic [3:0] rsp_result;
`ifdef ALU_ARB_FLAGS_EN
  logic       rsp_zero;
  logic       rsp_carry;
  logic       cap_zero;
  logic       cap_carry;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] cap_res;
  logic       cap_id;

  always #5 clk = ~clk;

  alu_arbiter #(.W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
`ifdef ALU_ARB_FLAGS_EN
    .rsp_zero   (rsp_zero),
    .rsp_carry  (rsp_carry),
`endif
    .rsp_result (rsp_result)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one op from requester n, hold until accepted, then
  // count negedges (accept cycle = 0) until rsp_valid is seen.
  task automatic run_op(input int n, input logic [3:0] a,
                        input logic [3:0] b, input logic [1:0] op,
                        output int lat);
    int waitc;
    @(negedge clk);
    if (n == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
    #1;
    waitc = 0;
    while (!((n == 0) ? req0_ready : req1_ready) && waitc < 10) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    cap_res = rsp_result;
    cap_id  = rsp_id;
`ifdef ALU_ARB_FLAGS_EN
    cap_zero  = rsp_zero;
    cap_carry = rsp_carry;
`endif
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid);
    end
    n_cmp++;
    if (rsp_result !== 4'd0) begin
      n_bad++; $display("FAIL reset_result got %0d want 0", rsp_result);
    end
    n_cmp++;
    if (rsp_id !== 1'b0) begin
      n_bad++; $display("FAIL reset_id got %b want 0", rsp_id);
    end
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_bad++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready});
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat;
    rsp_ready = 1'b1;
    run_op(0, 4'd7, 4'd9, OP_ADD, lat);
    n_cmp++;
    if (lat !== 2) begin
      n_bad++; $display("FAIL add_latency got %0d want 2", lat);
    end
    n_cmp++;
    if (cap_res !== 4'd0) begin
      n_bad++; $display("FAIL add_result got %0d want 0", cap_res);
    end
    n_cmp++;
    if (cap_id !== 1'b0) begin
      n_bad++; $display("FAIL add_id got %b want 0", cap_id);
    end
`ifdef ALU_ARB_FLAGS_EN
    n_cmp++;
    if ({cap_zero, cap_carry} !== 2'b11) begin
      n_bad++; $display("FAIL add_flags got %b want 11", {cap_zero, cap_carry});
    end
`endif
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL add_consumed got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_sub();
    int lat;
    run_op(1, 4'd3, 4'd5, OP_SUB, lat);
    n_cmp++;
    if (lat !== 2) begin
      n_bad++; $display("FAIL sub_latency got %0d want 2", lat);
    end
    n_cmp++;
    if (cap_res !== 4'd14) begin
      n_bad++; $display("FAIL sub_result got %0d want 14", cap_res);
    end
    n_cmp++;
    if (cap_id !== 1'b1) begin
      n_bad++; $display("FAIL sub_id got %b want 1", cap_id);
    end
`ifdef ALU_ARB_FLAGS_EN
    n_cmp++;
    if ({cap_zero, cap_carry} !== 2'b01) begin
      n_bad++; $display("FAIL sub_flags got %b want 01", {cap_zero, cap_carry});
    end
`endif
  endtask

  task automatic test_logic();
    int lat;
    run_op(0, 4'd12, 4'd10, OP_AND, lat);
    n_cmp++;
    if (cap_res !== 4'd8) begin
      n_bad++; $display("FAIL and_result got %0d want 8", cap_res);
    end
`ifdef ALU_ARB_FLAGS_EN
    n_cmp++;
    if (cap_carry !== 1'b0) begin
      n_bad++; $display("FAIL and_carry got %b want 0", cap_carry);
    end
`endif
    run_op(1, 4'd12, 4'd3, OP_OR, lat);
    n_cmp++;
    if (cap_res !== 4'd15) begin
      n_bad++; $display("FAIL or_result got %0d want 15", cap_res);
    end
    n_cmp++;
    if (cap_id !== 1'b1) begin
      n_bad++; $display("FAIL or_id got %b want 1", cap_id);
    end
`ifdef ALU_ARB_FLAGS_EN
    n_cmp++;
    if (cap_carry !== 1'b0) begin
      n_bad++; $display("FAIL or_carry got %b want 0", cap_carry);
    end
`endif
  endtask

  task automatic test_round_robin();
    int   g_cyc[$];
    logic g_id[$];
    logic r_id[$];
    do_reset();
    rsp_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req0_op = OP_ADD;
    req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd1; req1_op = OP_SUB;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req0_ready | req1_ready) begin
        g_cyc.push_back(i);
        g_id.push_back(req1_ready);
      end
      if (rsp_valid) r_id.push_back(rsp_id);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n_cmp++;
    if (g_cyc.size() !== 4) begin
      n_bad++; $display("FAIL rr_grant_count got %0d want 4", g_cyc.size());
    end
    n_cmp++;
    if (r_id.size() !== 4) begin
      n_bad++; $display("FAIL rr_rsp_count got %0d want 4", r_id.size());
    end
    for (int k = 0; k < 4 && k < g_cyc.size(); k++) begin
      n_cmp++;
      if (g_id[k] !== k[0]) begin
        n_bad++; $display("FAIL rr_grant_%0d got %b want %b", k, g_id[k], k[0]);
      end
      n_cmp++;
      if (g_cyc[k] !== 3 * k) begin
        n_bad++; $display("FAIL rr_cycle_%0d got %0d want %0d", k, g_cyc[k], 3 * k);
      end
    end
    for (int k = 0; k < 4 && k < r_id.size(); k++) begin
      n_cmp++;
      if (r_id[k] !== k[0]) begin
        n_bad++; $display("FAIL rr_rsp_id_%0d got %b want %b", k, r_id[k], k[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad_hold;
    do_reset();
    rsp_ready = 1'b0;
    run_op(0, 4'd12, 4'd3, OP_OR, lat);
    n_cmp++;
    if (lat !== 2 || cap_res !== 4'd15) begin
      n_bad++; $display("FAIL bp_first got lat %0d res %0d want 2 15", lat, cap_res);
    end
    req1_valid = 1'b1; req1_a = 4'd12; req1_b = 4'd10; req1_op = OP_AND;
    req0_a = 4'd9;
    bad_hold = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (rsp_valid !== 1'b1 || rsp_result !== 4'd15 || rsp_id !== 1'b0
          || req0_ready !== 1'b0 || req1_ready !== 1'b0)
        bad_hold++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad_hold !== 0) begin
      n_bad++; $display("FAIL bp_hold got %0d bad cycles want 0", bad_hold);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_release got %b want 0", rsp_valid);
    end
    n_cmp++;
    if (req1_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_resume got %b want 1", req1_ready);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_result !== 4'd8 || rsp_id !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_second got v%b r%0d id%b want v1 r8 id1",
               rsp_valid, rsp_result, rsp_id);
    end
  endtask

  task automatic test_reset_in_resp();
    int seen;
    do_reset();
    rsp_ready = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_op = OP_ADD;
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2; req1_op = OP_ADD;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_bad++; $display("FAIL rr_pre_reset got %b want 1", rsp_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_result !== 4'd0) begin
      n_bad++; $display("FAIL rst_resp got v%b r%0d want v0 r0", rsp_valid, rsp_result);
    end
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_bad++; $display("FAIL rst_first_grant got %b want 10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL rst_no_rsp got %0d want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_round_robin();
    test_backpressure();
    test_reset_in_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
